// File: rtl/data_memory_ctrl_if.sv
// Request/acknowledge bus between a data-side requester and data_memory_ctrl.
// Carries the access fields, the one-cycle ack_o pulse with its result, and busy_o.
interface data_memory_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  // Handshake: the controller samples req_i and the access fields only while
  // idle (busy_o = 0). Once sampled, the access completes with exactly one
  // ack_o pulse, and rdata_o/err_o are valid in that cycle. A req_i still high
  // after ack_o starts a new, identical access.
  logic                  req_i;
  logic                  we_i;
  logic [1:0]            size_i;
  logic                  unsigned_i;
  logic [DATA_WIDTH-1:0] addr_i;
  logic [DATA_WIDTH-1:0] wdata_i;
  logic [DATA_WIDTH-1:0] rdata_o;
  logic                  ack_o;
  logic                  err_o;
  logic                  busy_o;

  modport master (
    output req_i, we_i, size_i, unsigned_i, addr_i, wdata_i,
    input  rdata_o, ack_o, err_o, busy_o
  );

  modport slave (
    input  req_i, we_i, size_i, unsigned_i, addr_i, wdata_i,
    output rdata_o, ack_o, err_o, busy_o
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// Data-RAM controller with wait states, little-endian byte/half/word lanes and error flags.
// Optional misalignment checking is enabled by defining DATA_MEMORY_ALIGN_CHECK_EN.
module data_memory_ctrl #(
  parameter int          DATA_WIDTH   = 32,
  parameter int          MEMORY_DEPTH = 64,
  parameter logic [31:0] DATA_BASE    = 32'h1001_0000,
  parameter int          WAIT_STATES  = 1
) (
  input  logic              clk,
  input  logic              reset,
  data_memory_ctrl_if.slave bus,
  output logic [1:0]        dbg_state
);
  localparam int          IDXW     = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
  localparam logic [32:0] ADDR_END = 33'(DATA_BASE) + 33'(4 * MEMORY_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  we_q;
  logic [1:0]            size_q;
  logic                  uns_q;

  logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

  logic [DATA_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic                  acc_we;
  logic [1:0]            acc_size;
  logic                  acc_uns;
  logic                  acc_err;
  logic                  in_range;
  logic                  misaligned;
  logic                  commit;
  logic                  ram_we;
  logic [IDXW-1:0]       idx;
  logic [3:0]            be;
  logic [DATA_WIDTH-1:0] wlane;
  logic [DATA_WIDTH-1:0] rword;
  logic [7:0]            rbyte;
  logic [15:0]           rhalf;
  logic [DATA_WIDTH-1:0] load_val;

  assign dbg_state = state;

  // With zero wait states the access commits straight out of IDLE, so the
  // fields come from the bus instead of the latches in that case.
  always_comb begin
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_we    = we_q;
    acc_size  = size_q;
    acc_uns   = uns_q;
    if (state == IDLE) begin
      acc_addr  = bus.addr_i;
      acc_wdata = bus.wdata_i;
      acc_we    = bus.we_i;
      acc_size  = bus.size_i;
      acc_uns   = bus.unsigned_i;
    end
  end

  assign commit = ((state == IDLE) && bus.req_i && (WAIT_STATES == 0)) ||
                  ((state == WAIT) && (cnt == 4'd1));

  always_comb begin
    in_range   = ({1'b0, acc_addr} >= 33'(DATA_BASE)) && ({1'b0, acc_addr} < ADDR_END);
    misaligned = 1'b0;
`ifdef DATA_MEMORY_ALIGN_CHECK_EN
    misaligned = ((acc_size == 2'b01) && acc_addr[0]) ||
                 ((acc_size == 2'b10) && (acc_addr[1:0] != 2'b00));
`endif
    acc_err = !in_range || (acc_size == 2'b11) || misaligned;
    idx     = IDXW'((acc_addr - DATA_BASE) >> 2);
  end

  // Byte enables and replicated store data; misaligned halfword/word
  // addresses simply drop their low bits here.
  always_comb begin
    be    = 4'b0000;
    wlane = acc_wdata;
    case (acc_size)
      2'b00: begin
        be    = 4'b0001 << acc_addr[1:0];
        wlane = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        be    = acc_addr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{acc_wdata[15:0]}};
      end
      2'b10: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_comb begin
    rword    = mem[idx];
    rbyte    = rword[{acc_addr[1:0], 3'b000} +: 8];
    rhalf    = acc_addr[1] ? rword[31:16] : rword[15:0];
    load_val = rword;
    case (acc_size)
      2'b00:   load_val = {{24{!acc_uns && rbyte[7]}}, rbyte};
      2'b01:   load_val = {{16{!acc_uns && rhalf[15]}}, rhalf};
      default: load_val = rword;
    endcase
  end

  assign ram_we = commit && acc_we && !acc_err;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      bus.rdata_o <= '0;
      bus.ack_o   <= 1'b0;
      bus.err_o   <= 1'b0;
      bus.busy_o  <= 1'b0;
    end else begin
      bus.ack_o <= 1'b0;
      if (commit) begin
        bus.ack_o <= 1'b1;
        bus.err_o <= acc_err;
        if (acc_err)     bus.rdata_o <= '0;
        else if (!acc_we) bus.rdata_o <= load_val;
      end
      case (state)
        IDLE: begin
          if (bus.req_i) begin
            addr_q     <= bus.addr_i;
            wdata_q    <= bus.wdata_i;
            we_q       <= bus.we_i;
            size_q     <= bus.size_i;
            uns_q      <= bus.unsigned_i;
            cnt        <= 4'(WAIT_STATES);
            bus.busy_o <= 1'b1;
            state      <= (WAIT_STATES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP: begin
          bus.busy_o <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
